// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer, one G/P full-adder cell reused LSB first
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             g_grp,
  output logic             p_grp,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry, g_acc, p_acc;
  logic [CNT_W-1:0] idx;

  logic             accept, last_bit;
  logic             g_i, p_i, carry_nx, g_acc_nx, p_acc_nx;
  logic [WIDTH-1:0] bit_mask, b_eff;
  logic             carry_eff;

`ifdef SERIAL_ADD_SUB_EN
  // a - b is a + ~b + 1, so the carry-in is forced and cin is ignored
  assign b_eff     = sub ? ~b : b;
  assign carry_eff = sub ? 1'b1 : cin;
`else
  assign b_eff     = b;
  assign carry_eff = cin;
`endif

  assign accept   = in_valid & in_ready;
  assign last_bit = (idx == CNT_W'(WIDTH - 1));
  assign g_i      = a_sh[0] & b_sh[0];
  assign p_i      = a_sh[0] ^ b_sh[0];
  assign carry_nx = g_i | (p_i & carry);
  assign g_acc_nx = g_i | (p_i & g_acc);
  assign p_acc_nx = p_acc & p_i;
  assign bit_mask = WIDTH'(1) << idx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      g_acc <= 1'b0;
      p_acc <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      g_grp <= 1'b0;
      p_grp <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= carry_eff;
            g_acc <= 1'b0;
            p_acc <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          // operands shift right so the active bit is always at position 0
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= (p_i ^ carry) ? (sum | bit_mask) : (sum & ~bit_mask);
          carry <= carry_nx;
          g_acc <= g_acc_nx;
          p_acc <= p_acc_nx;
          if (last_bit) begin
            cout  <= carry_nx;
            g_grp <= g_acc_nx;
            p_grp <= p_acc_nx;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with arithmetic reference model
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, g_grp, p_grp, busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .g_grp(g_grp), .p_grp(p_grp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing, 2 result presented
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_sum = '0, n_sum;
  logic         m_cout = 0, m_g = 0, m_p = 0, n_cout, n_g, n_p;
  logic         started = 0;

  always @(posedge clk) begin
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full, nocarry;
    started <= 1'b1;
    if (rst) begin
      m_phase <= 0;
      m_sum <= '0; m_cout <= 0; m_g <= 0; m_p <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          bb = b; c = cin;
`ifdef SERIAL_ADD_SUB_EN
          if (sub) begin bb = ~b; c = 1'b1; end
`endif
          full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
          nocarry = {1'b0, a} + {1'b0, bb};
          n_sum  <= full[W-1:0];
          n_cout <= full[W];
          n_g    <= nocarry[W];
          n_p    <= &(a ^ bb);
          m_cnt  <= W;
          m_phase <= 1;
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_phase <= 2;
            m_sum <= n_sum; m_cout <= n_cout; m_g <= n_g; m_p <= n_p;
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      if (m_phase != 1) begin
        chk("model_sum", sum, m_sum);
        chk("model_cout", cout, m_cout);
        chk("model_g", g_grp, m_g);
        chk("model_p", p_grp, m_p);
        chk("invariant", cout, m_g | (m_p & (m_cout & ~m_g)) | (m_cout & m_g));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin step(1); cyc++; end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eg, input logic ep);
    int cyc;
    out_ready = 1'b1;
    start_op(ta, tb, tc, ts);
    wait_done(cyc);
    chk({nm, "_latency"}, cyc, W);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_g"}, g_grp, eg);
    chk({nm, "_p"}, p_grp, ep);
    step(1);
    chk({nm, "_idle_ready"}, in_ready, 1'b1);
    chk({nm, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int cyc;
    step(2);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, g_grp, p_grp}, 3'b000);

    run_op("t1", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
    run_op("t2", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("t3", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("t3b", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    run_op("t3c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);

    // back-pressure with stray requests during RUN and DONE
    out_ready = 1'b0;
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    a = 8'h11; b = 8'h11; in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    wait_done(cyc);
    chk("t4_latency", cyc, W - 2);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_sum", sum, 8'h4B);
      chk("t4_hold_flags", {cout, g_grp, p_grp}, 3'b000);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_in_ready", in_ready, 1'b0);
      step(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    chk("t4_after_hs_valid", out_valid, 1'b0);
    chk("t4_after_hs_sum", sum, 8'h4B);
    step(1);
    chk("t4_still_idle", busy, 1'b0);

    // reset during the third RUN cycle
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_sum", sum, 0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cyc++;
      step(1);
    end
    chk("t5_no_valid", cyc, 0);

    run_op("t7", 8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    run_op("t6a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
    run_op("t6b", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("t6c", 8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
